// File: rtl/bcd_step_counter.sv
// Single-digit BCD step counter for a 7-segment decoder.
// The digit advances on a debounced key press (manual mode) or on a divided
// clock tick (auto mode). It counts up or down with wrap, and it emits a
// one-cycle CARRY pulse on wrap so that digits can be cascaded.
// All inputs are synchronized with two flops. All outputs are registered.
module bcd_step_counter #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int TICK_DIV        = 50000000
) (
   input  logic       CLOCK_50,
   input  logic       RST_N,
   input  logic       KEY_STEP,
   input  logic       SW_UP,
   input  logic       SW_AUTO,
   input  logic       SW_CLR,
   output logic [3:0] BCD,
   output logic       CARRY,
   output logic       STEP
);

   // Counter widths. The guard keeps DW at least 1 bit when DEBOUNCE_CYCLES is 1.
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   // Synchronizer stages. The key is active-low, so its idle level is 1.
   logic k_m, k_s;
   logic up_m, up_s;
   logic auto_m, auto_s;
   logic clr_m, clr_s;

   // Debounce state
   logic          deb, deb_prev, deb_nxt;
   logic [DW-1:0] dcnt, dcnt_nxt;

   // Prescaler state
   logic [PW-1:0] pcnt, pcnt_nxt;
   logic          tick;

   // Step events and the next digit state
   logic       press, step;
   logic [3:0] bcd_nxt;
   logic       carry_nxt, step_nxt;

   // Two-flop synchronizers for all asynchronous inputs
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         k_m    <= 1'b1;
         k_s    <= 1'b1;
         up_m   <= 1'b0;
         up_s   <= 1'b0;
         auto_m <= 1'b0;
         auto_s <= 1'b0;
         clr_m  <= 1'b0;
         clr_s  <= 1'b0;
      end else begin
         k_m    <= KEY_STEP;
         k_s    <= k_m;
         up_m   <= SW_UP;
         up_s   <= up_m;
         auto_m <= SW_AUTO;
         auto_s <= auto_m;
         clr_m  <= SW_CLR;
         clr_s  <= clr_m;
      end
   end

   // Debounce next state: accept a new level after DEBOUNCE_CYCLES consecutive differing cycles
   always_comb begin
      deb_nxt  = deb;
      dcnt_nxt = '0;
      if (k_s != deb) begin
         if (dcnt == DMAX) begin
            deb_nxt = k_s;
         end else begin
            dcnt_nxt = dcnt + DW'(1);
         end
      end
   end

   // Debounce registers. deb_prev delays deb by one cycle for press edge detection.
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         deb      <= 1'b1;
         deb_prev <= 1'b1;
         dcnt     <= '0;
      end else begin
         deb      <= deb_nxt;
         deb_prev <= deb;
         dcnt     <= dcnt_nxt;
      end
   end

   // A press is the falling edge of the debounced level. It is one cycle per press, and releases are ignored.
   assign press = deb_prev & ~deb;

   // Prescaler next state. It wraps at TICK_DIV-1 and is held at zero outside auto mode.
   always_comb begin
      tick     = auto_s && (pcnt == PMAX);
      pcnt_nxt = '0;
      if (auto_s && !tick) begin
         pcnt_nxt = pcnt + PW'(1);
      end
   end

   // Prescaler register
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt_nxt;
      end
   end

   // Step source. In auto mode only the tick counts, so key presses are ignored.
   assign step = auto_s ? tick : press;

   // Digit next state. Clear has priority over a step. Direction is sampled only at the step.
   always_comb begin
      bcd_nxt   = BCD;
      carry_nxt = 1'b0;
      step_nxt  = step & ~clr_s;
      if (clr_s) begin
         bcd_nxt = 4'd0;
      end else if (step) begin
         if (BCD > 4'd9) begin
            // Unreachable illegal code: recover to 0 without a carry
            bcd_nxt = 4'd0;
         end else if (up_s) begin
            bcd_nxt   = (BCD == 4'd9) ? 4'd0 : BCD + 4'd1;
            carry_nxt = (BCD == 4'd9);
         end else begin
            bcd_nxt   = (BCD == 4'd0) ? 4'd9 : BCD - 4'd1;
            carry_nxt = (BCD == 4'd0);
         end
      end
   end

   // Registered outputs
   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         BCD   <= 4'd0;
         CARRY <= 1'b0;
         STEP  <= 1'b0;
      end else begin
         BCD   <= bcd_nxt;
         CARRY <= carry_nxt;
         STEP  <= step_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed testbench for bcd_step_counter with DEBOUNCE_CYCLES=4 and TICK_DIV=5.
// Inputs are driven, and outputs are sampled, on the falling clock edge.
module tb_bcd_step_counter;

   localparam int DEB  = 4;
   localparam int TDIV = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       key = 1'b1;
   logic       sw_up = 1'b0;
   logic       sw_auto = 1'b0;
   logic       sw_clr = 1'b0;
   logic [3:0] bcd;
   logic       carry;
   logic       step;

   int total = 0;
   int bad   = 0;

   // Pulse counters are updated just after each rising edge.
   int step_cnt  = 0;
   int carry_cnt = 0;
   logic [3:0] carry_bcd = 4'd15;

   bcd_step_counter #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
      .CLOCK_50 (clk),
      .RST_N    (rst_n),
      .KEY_STEP (key),
      .SW_UP    (sw_up),
      .SW_AUTO  (sw_auto),
      .SW_CLR   (sw_clr),
      .BCD      (bcd),
      .CARRY    (carry),
      .STEP     (step)
   );

   // Clock generation: 10 ns period, first rising edge at 5 ns
   always #5 clk = ~clk;

   // Count STEP and CARRY pulses, one count per cycle high
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (step) step_cnt = step_cnt + 1;
         if (carry) begin
            carry_cnt = carry_cnt + 1;
            carry_bcd = bcd;
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Clean press: low for 10 cycles, then released for 10 cycles
   task automatic press_key();
      key = 1'b0;
      wait_cycles(10);
      key = 1'b1;
      wait_cycles(10);
   endtask

   task automatic clear_digit();
      sw_clr = 1'b1;
      wait_cycles(4);
      sw_clr = 1'b0;
      wait_cycles(3);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      total++; if (bcd !== 4'd0) begin bad++; $display("FAIL reset_bcd got=%0d want=0", bcd); end
      total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", carry); end
      total++; if (step !== 1'b0) begin bad++; $display("FAIL reset_step got=%b want=0", step); end
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(2);
   endtask

   task automatic test_debounce();
      int s0;
      sw_up = 1'b1;
      wait_cycles(3);
      s0 = step_cnt;
      // Glitches of 3 low cycles are one short of acceptance
      for (int i = 0; i < 5; i++) begin
         key = 1'b0;
         wait_cycles(3);
         key = 1'b1;
         wait_cycles(3);
      end
      wait_cycles(10);
      total++; if (step_cnt - s0 != 0) begin bad++; $display("FAIL glitch_steps got=%0d want=0", step_cnt - s0); end
      total++; if (bcd !== 4'd0) begin bad++; $display("FAIL glitch_bcd got=%0d want=0", bcd); end
      // Solid press: BCD changes at the 7th rising edge after the fall
      key = 1'b0;
      wait_cycles(6);
      total++; if (bcd !== 4'd0) begin bad++; $display("FAIL latency_edge6_bcd got=%0d want=0", bcd); end
      wait_cycles(1);
      total++; if (bcd !== 4'd1) begin bad++; $display("FAIL latency_edge7_bcd got=%0d want=1", bcd); end
      total++; if (step !== 1'b1) begin bad++; $display("FAIL latency_edge7_step got=%b want=1", step); end
      wait_cycles(1);
      total++; if (step !== 1'b0) begin bad++; $display("FAIL step_width got=%b want=0", step); end
      wait_cycles(2);
      key = 1'b1;
      wait_cycles(10);
      total++; if (step_cnt - s0 != 1) begin bad++; $display("FAIL hold_steps got=%0d want=1", step_cnt - s0); end
      total++; if (bcd !== 4'd1) begin bad++; $display("FAIL hold_bcd got=%0d want=1", bcd); end
   endtask

   task automatic test_up_wrap();
      int c0;
      int s0;
      logic [3:0] exp;
      clear_digit();
      total++; if (bcd !== 4'd0) begin bad++; $display("FAIL up_start_bcd got=%0d want=0", bcd); end
      c0 = carry_cnt;
      s0 = step_cnt;
      for (int i = 1; i <= 10; i++) begin
         press_key();
         exp = 4'(i % 10);
         total++; if (bcd !== exp) begin bad++; $display("FAIL up_seq_%0d got=%0d want=%0d", i, bcd, exp); end
         if (i == 9) begin
            total++; if (carry_cnt != c0) begin bad++; $display("FAIL up_early_carry got=%0d want=%0d", carry_cnt, c0); end
         end
      end
      total++; if (carry_cnt - c0 != 1) begin bad++; $display("FAIL up_carry_count got=%0d want=1", carry_cnt - c0); end
      total++; if (carry_bcd !== 4'd0) begin bad++; $display("FAIL up_carry_bcd got=%0d want=0", carry_bcd); end
      total++; if (step_cnt - s0 != 10) begin bad++; $display("FAIL up_steps got=%0d want=10", step_cnt - s0); end
   endtask

   task automatic test_down_wrap();
      int c0;
      sw_up = 1'b0;
      wait_cycles(3);
      c0 = carry_cnt;
      press_key();
      total++; if (bcd !== 4'd9) begin bad++; $display("FAIL down_wrap_bcd got=%0d want=9", bcd); end
      total++; if (carry_cnt - c0 != 1) begin bad++; $display("FAIL down_wrap_carry got=%0d want=1", carry_cnt - c0); end
      total++; if (carry_bcd !== 4'd9) begin bad++; $display("FAIL down_carry_bcd got=%0d want=9", carry_bcd); end
      press_key();
      total++; if (bcd !== 4'd8) begin bad++; $display("FAIL down_second_bcd got=%0d want=8", bcd); end
      total++; if (carry_cnt - c0 != 1) begin bad++; $display("FAIL down_second_carry got=%0d want=1", carry_cnt - c0); end
      // Direction toggles without a step never change the digit
      for (int i = 0; i < 4; i++) begin
         sw_up = ~sw_up;
         wait_cycles(3);
      end
      total++; if (bcd !== 4'd8) begin bad++; $display("FAIL dir_toggle_bcd got=%0d want=8", bcd); end
   endtask

   task automatic test_auto();
      int s0;
      sw_up = 1'b1;
      sw_auto = 1'b1;
      wait_cycles(6);
      total++; if (bcd !== 4'd8) begin bad++; $display("FAIL auto_pre_tick_bcd got=%0d want=8", bcd); end
      wait_cycles(1);
      total++; if (bcd !== 4'd9) begin bad++; $display("FAIL auto_first_tick_bcd got=%0d want=9", bcd); end
      wait_cycles(5);
      total++; if (bcd !== 4'd0) begin bad++; $display("FAIL auto_second_tick_bcd got=%0d want=0", bcd); end
      // A key press spanning 20 cycles adds nothing to the 4 ticks
      s0 = step_cnt;
      press_key();
      total++; if (step_cnt - s0 != 4) begin bad++; $display("FAIL auto_key_steps got=%0d want=4", step_cnt - s0); end
      total++; if (bcd !== 4'd4) begin bad++; $display("FAIL auto_key_bcd got=%0d want=4", bcd); end
      sw_auto = 1'b0;
      s0 = step_cnt;
      wait_cycles(20);
      total++; if (step_cnt - s0 != 0) begin bad++; $display("FAIL auto_off_steps got=%0d want=0", step_cnt - s0); end
      total++; if (bcd !== 4'd4) begin bad++; $display("FAIL auto_off_bcd got=%0d want=4", bcd); end
   endtask

   task automatic test_clear();
      int s0;
      int c0;
      bit seen;
      s0 = step_cnt;
      c0 = carry_cnt;
      sw_clr = 1'b1;
      sw_auto = 1'b1;
      wait_cycles(20);
      total++; if (bcd !== 4'd0) begin bad++; $display("FAIL clr_bcd got=%0d want=0", bcd); end
      total++; if (step_cnt - s0 != 0) begin bad++; $display("FAIL clr_steps got=%0d want=0", step_cnt - s0); end
      total++; if (carry_cnt - c0 != 0) begin bad++; $display("FAIL clr_carry got=%0d want=0", carry_cnt - c0); end
      sw_clr = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12 && !seen; i++) begin
         @(negedge clk);
         if (step) seen = 1'b1;
      end
      total++; if (!seen) begin bad++; $display("FAIL clr_resume_timeout got=no_step want=step"); end
      total++; if (bcd !== 4'd1) begin bad++; $display("FAIL clr_resume_bcd got=%0d want=1", bcd); end
   endtask

   task automatic test_async_reset();
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 60 && !hit; i++) begin
         @(negedge clk);
         if (bcd == 4'd7) hit = 1'b1;
      end
      total++; if (!hit) begin bad++; $display("FAIL areset_reach7 got=%0d want=7", bcd); end
      // Assert reset between edges and check the outputs with no clock edge in between
      #2 rst_n = 1'b0;
      #1;
      total++; if (bcd !== 4'd0) begin bad++; $display("FAIL areset_bcd got=%0d want=0", bcd); end
      total++; if (carry !== 1'b0) begin bad++; $display("FAIL areset_carry got=%b want=0", carry); end
      total++; if (step !== 1'b0) begin bad++; $display("FAIL areset_step got=%b want=0", step); end
      sw_auto = 1'b0;
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(10);
      total++; if (bcd !== 4'd0) begin bad++; $display("FAIL post_reset_bcd got=%0d want=0", bcd); end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_up_wrap();
      test_down_wrap();
      test_auto();
      test_clear();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
